// File: rtl/rv32i_pkg.sv
// RV32I encoding constants shared by the instruction encoder and its bench:
// the bundle format codes, the major opcodes and the bit positions of the common fields.
package rv32i_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6F;

    localparam int OPCODE_LSB = 0;
    localparam int RD_LSB     = 7;
    localparam int FUNCT3_LSB = 12;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;
    localparam int FUNCT7_LSB = 25;

endpackage

// File: rtl/instruction_encoder_if.sv
// Session control, field-bundle handshake and instruction-memory write port of the encoder.
// The master side supplies bundles and accepts memory writes; the encoder is the slave.
interface instruction_encoder_if #(
    parameter int IMEM_AW = 10
);
    logic               start;
    logic [IMEM_AW-1:0] base_addr;
    logic               in_valid;
    logic               in_ready;
    logic               last;
    logic [2:0]         fmt;
    logic [6:0]         opcode;
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [31:0]        imm;
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_wdata;
    logic               imem_ready;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output start, base_addr, in_valid, last, fmt, opcode, rd, rs1, rs2,
               funct3, funct7, imm, imem_ready,
        input  in_ready, imem_we, imem_addr, imem_wdata, busy, done, err
    );

    modport slave (
        input  start, base_addr, in_valid, last, fmt, opcode, rd, rs1, rs2,
               funct3, funct7, imm, imem_ready,
        output in_ready, imem_we, imem_addr, imem_wdata, busy, done, err
    );

endinterface

// File: rtl/instruction_encoder_sync_fifo.sv
// Single-clock FIFO buffering encoded words between bundle acceptance and the memory
// output register. Push on full and pop on empty are ignored.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr_q];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/instruction_encoder.sv
// Packs RV32I field bundles into 32-bit instruction words, range-checks immediates and
// streams accepted words into instruction memory from a base address, one per cycle.
module instruction_encoder
    import rv32i_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int IMEM_AW    = 10
) (
    input logic                  clk,
    input logic                  rst_n,
    instruction_encoder_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN, ST_DONE} state_e;

    state_e             state_q, state_d;
    logic [IMEM_AW-1:0] addr_cnt_q, addr_cnt_d;
    logic               imem_we_q, imem_we_d;
    logic [IMEM_AW-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]        imem_wdata_q, imem_wdata_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [31:0] enc_word;
    logic        range_err;
    logic        in_ready, accept;
    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [31:0] fifo_rdata;

    always_comb begin
        enc_word  = '0;
        range_err = 1'b0;
        enc_word[OPCODE_LSB +: 7] = bus.opcode;
        case (bus.fmt)
            FMT_R: begin
                enc_word[RD_LSB +: 5]     = bus.rd;
                enc_word[FUNCT3_LSB +: 3] = bus.funct3;
                enc_word[RS1_LSB +: 5]    = bus.rs1;
                enc_word[RS2_LSB +: 5]    = bus.rs2;
                enc_word[FUNCT7_LSB +: 7] = bus.funct7;
            end
            FMT_I: begin
                enc_word[RD_LSB +: 5]     = bus.rd;
                enc_word[FUNCT3_LSB +: 3] = bus.funct3;
                enc_word[RS1_LSB +: 5]    = bus.rs1;
                enc_word[31:20]           = bus.imm[11:0];
                range_err = (bus.imm[31:11] != {21{bus.imm[11]}});
            end
            FMT_S: begin
                enc_word[FUNCT3_LSB +: 3] = bus.funct3;
                enc_word[RS1_LSB +: 5]    = bus.rs1;
                enc_word[RS2_LSB +: 5]    = bus.rs2;
                enc_word[31:25]           = bus.imm[11:5];
                enc_word[11:7]            = bus.imm[4:0];
                range_err = (bus.imm[31:11] != {21{bus.imm[11]}});
            end
            FMT_B: begin
                enc_word[FUNCT3_LSB +: 3] = bus.funct3;
                enc_word[RS1_LSB +: 5]    = bus.rs1;
                enc_word[RS2_LSB +: 5]    = bus.rs2;
                enc_word[31]              = bus.imm[12];
                enc_word[30:25]           = bus.imm[10:5];
                enc_word[11:8]            = bus.imm[4:1];
                enc_word[7]               = bus.imm[11];
                range_err = (bus.imm[31:12] != {20{bus.imm[12]}}) || bus.imm[0];
            end
            FMT_U: begin
                enc_word[RD_LSB +: 5] = bus.rd;
                enc_word[31:12]       = bus.imm[31:12];
                range_err = (bus.imm[11:0] != 12'd0);
            end
            FMT_J: begin
                enc_word[RD_LSB +: 5] = bus.rd;
                enc_word[31]          = bus.imm[20];
                enc_word[30:21]       = bus.imm[10:1];
                enc_word[20]          = bus.imm[11];
                enc_word[19:12]       = bus.imm[19:12];
                range_err = (bus.imm[31:20] != {12{bus.imm[20]}}) || bus.imm[0];
            end
            default: range_err = 1'b1;
        endcase
    end

    // Dropped bundles still count as accepted so a bad last bundle ends the session.
    assign in_ready  = (state_q == ST_LOAD) && !fifo_full;
    assign accept    = bus.in_valid && in_ready;
    assign fifo_push = accept && !range_err;
    assign fifo_pop  = !fifo_empty && (!imem_we_q || bus.imem_ready);

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (enc_word),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        addr_cnt_d   = addr_cnt_q;
        err_d        = err_q;
        imem_we_d    = imem_we_q && !bus.imem_ready;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;

        // The output register reloads in the same cycle its word completes.
        if (fifo_pop) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = addr_cnt_q;
            imem_wdata_d = fifo_rdata;
            addr_cnt_d   = addr_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d    = ST_LOAD;
                    addr_cnt_d = bus.base_addr;
                    err_d      = 1'b0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    if (range_err) err_d = 1'b1;
                    if (bus.last)  state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: if (fifo_empty && !imem_we_q) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_LOAD) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            addr_cnt_q   <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_cnt_q   <= addr_cnt_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;

endmodule
